part_2_targ_endpoint: RTL

Target-side endpoint of the partition-2 cosimulation link: the responder that pairs with the initiator, which exports per-mission-clock input frames and imports the target's `{valid, o_data}` result. It collects the three inbound event payloads (events 0–2, each `{wen, data}`) from the transport stream and drives them into the target partition. It then issues a single mission-clock step, captures the partition's `{valid, o_data}`, and returns it as event 3. It sits between the link transport and the target partition logic, and stalls the partition's clock generator while a frame is incomplete.

---
 rtl/part_2_link_pkg.sv | 23 ++
 rtl/part_2_watchdog.sv | 31 +++
 rtl/part_2_targ_endpoint.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/part_2_link_pkg.sv
// Shared types for the partition-2 cosimulation link: event numbers,
// payload format and the target endpoint's state encoding.
package part_2_link_pkg;

    typedef enum logic [1:0] {EV_CLK0, EV_CLK1, EV_CLK2, EV_CLK3} event_t;

    typedef logic [8:0] payload_t;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_STEP,
        ST_CAPTURE,
        ST_SEND,
        ST_ERROR
    } ep_state_t;

    // Event number carrying the target's {valid, o_data} result back
    localparam event_t EV_RESULT = EV_CLK3;

    // Number of inbound input events that make up one frame
    localparam int NUM_IN_EVENTS = 3;

endpackage

// File: rtl/part_2_watchdog.sv
// Idle-cycle watchdog: counts armed cycles without a kick and flags
// expiry once WATCHDOG_MAX such cycles have elapsed.
module part_2_watchdog #(
    parameter int WATCHDOG_MAX = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arm,
    input  logic kick,
    output logic expired
);

    localparam int CW = (WATCHDOG_MAX < 2) ? 1 : $clog2(WATCHDOG_MAX + 1);

    logic [CW-1:0] count_reg;

    // Count idle armed cycles; any kick or disarm restarts from zero, and the
    // count saturates at the limit so expiry stays asserted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (!arm || kick) begin
            count_reg <= '0;
        end else if (count_reg != CW'(WATCHDOG_MAX)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = (count_reg == CW'(WATCHDOG_MAX));

endmodule

// File: rtl/part_2_targ_endpoint.sv
// Target-side endpoint of the partition-2 link: gathers the three inbound
// input events, steps the target partition once, and returns its result as
// event 3. The partition's clock generator is frozen during partial frames.
module part_2_targ_endpoint
    import part_2_link_pkg::*;
#(
    parameter int PW           = 9,
    parameter int WATCHDOG_MAX = 100,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [1:0]       rx_event,
    input  logic [PW-1:0]    rx_payload,
    output logic             wen0,
    output logic             wen1,
    output logic             wen2,
    output logic [7:0]       i_data0,
    output logic [7:0]       i_data1,
    output logic [7:0]       i_data2,
    output logic             step_o,
    input  logic             valid,
    input  logic [7:0]       o_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [1:0]       tx_event,
    output logic [PW-1:0]    tx_payload,
    output logic             freeze_clk,
    output logic             proto_err,
    output logic             wd_error,
    output logic [CNT_W-1:0] step_cnt
);

    ep_state_t               state_reg;
    logic [2:0]              got_reg;
    logic                    step_reg;
    logic                    tx_valid_reg;
    logic [PW-1:0]           tx_payload_reg;
    logic                    proto_err_reg;
    logic                    wd_error_reg;
    logic [CNT_W-1:0]        step_cnt_reg;

    logic [2:0]              ev_mask;
    logic                    accept;
    logic                    ev_legal;
    logic                    store;
    logic [2:0]              got_next;
    logic                    frame_done;
    logic                    wd_arm;
    logic                    wd_expired;
    logic [PW-1:0]           drive_val [NUM_IN_EVENTS];

    // Decode the inbound beat: which slot it targets and whether it is new
    always_comb begin
        ev_mask = 3'b000;
        if (rx_event != EV_RESULT) begin
            ev_mask = 3'b001 << rx_event;
        end
        rx_ready   = (state_reg == ST_COLLECT) && !wd_expired;
        accept     = rx_valid && rx_ready;
        ev_legal   = (ev_mask != 3'b000) && ((got_reg & ev_mask) == 3'b000);
        store      = accept && ev_legal;
        got_next   = got_reg | (store ? ev_mask : 3'b000);
        frame_done = store && (got_next == 3'b111);
    end

    // One slot per input event plus the value driven into the partition
    for (genvar gi = 0; gi < NUM_IN_EVENTS; gi++) begin : g_slot
        logic [PW-1:0] slot_reg;
        logic [PW-1:0] drive_reg;
        logic          hit;

        assign hit = store && ev_mask[gi];

        // Capture the first payload seen for this event in the current frame
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                slot_reg <= '0;
            end else if (hit) begin
                slot_reg <= rx_payload;
            end
        end

        // Load the partition input on entry to STEP, bypassing the slot for
        // the beat that completes the frame so no bubble is needed
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                drive_reg <= '0;
            end else if (frame_done) begin
                drive_reg <= hit ? rx_payload : slot_reg;
            end
        end

        assign drive_val[gi] = drive_reg;
    end

    // Endpoint sequencing: collect, step, capture, send, or terminal error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_COLLECT;
            got_reg        <= 3'b000;
            step_reg       <= 1'b0;
            tx_valid_reg   <= 1'b0;
            tx_payload_reg <= '0;
            proto_err_reg  <= 1'b0;
            wd_error_reg   <= 1'b0;
            step_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_COLLECT: begin
                    if (wd_expired) begin
                        state_reg    <= ST_ERROR;
                        wd_error_reg <= 1'b1;
                    end else if (accept) begin
                        if (!ev_legal) begin
                            proto_err_reg <= 1'b1;
                        end
                        got_reg <= got_next;
                        if (frame_done) begin
                            state_reg <= ST_STEP;
                            step_reg  <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    step_reg  <= 1'b0;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    tx_payload_reg <= PW'({valid, o_data});
                    tx_valid_reg   <= 1'b1;
                    state_reg      <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        got_reg      <= 3'b000;
                        step_cnt_reg <= step_cnt_reg + CNT_W'(1);
                        state_reg    <= ST_COLLECT;
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg <= ST_ERROR;
                end
            endcase
        end
    end

    // Watchdog only runs while a partially filled frame is waiting
    assign wd_arm = (state_reg == ST_COLLECT) && (got_reg != 3'b000);

    part_2_watchdog #(
        .WATCHDOG_MAX (WATCHDOG_MAX)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .arm     (wd_arm),
        .kick    (accept),
        .expired (wd_expired)
    );

    assign freeze_clk = wd_arm || (state_reg == ST_ERROR);

    assign wen0       = drive_val[0][PW-1];
    assign wen1       = drive_val[1][PW-1];
    assign wen2       = drive_val[2][PW-1];
    assign i_data0    = drive_val[0][PW-2:0];
    assign i_data1    = drive_val[1][PW-2:0];
    assign i_data2    = drive_val[2][PW-2:0];

    assign step_o     = step_reg;
    assign tx_valid   = tx_valid_reg;
    assign tx_event   = tx_valid_reg ? EV_RESULT : EV_CLK0;
    assign tx_payload = tx_payload_reg;
    assign proto_err  = proto_err_reg;
    assign wd_error   = wd_error_reg;
    assign step_cnt   = step_cnt_reg;

endmodule
